// File: rtl/krnl_aes_engine_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// krnl_aes_engine_sched : kernel-run sequencer for AES_ENGINE_NUM AES engines
//   (key-expansion kick-off, round-robin block dispatch and in-order collect)
// Revision: 1.0
// ----------------------------------------------------------------------------
module krnl_aes_engine_sched #(
  parameter int AES_ENGINE_NUM = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic                          mode,
  input  logic [1:0]                    key_len,
  output logic                          eng_mode,
  output logic [1:0]                    eng_key_len,
  output logic                          key_exp_start,
  input  logic [AES_ENGINE_NUM-1:0]     key_exp_done,
  input  logic [127:0]                  s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  output logic [127:0]                  eng_in_data,
  output logic [AES_ENGINE_NUM-1:0]     eng_in_valid,
  input  logic [AES_ENGINE_NUM-1:0]     eng_in_ready,
  input  logic [128*AES_ENGINE_NUM-1:0] eng_out_data,
  input  logic [AES_ENGINE_NUM-1:0]     eng_out_valid,
  output logic [AES_ENGINE_NUM-1:0]     eng_out_ready,
  output logic [127:0]                  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [AES_ENGINE_NUM-1:0]     status
);

  localparam int EW = $clog2(AES_ENGINE_NUM);
  localparam int PW = $clog2(AES_ENGINE_NUM + 1);
  localparam logic [EW-1:0]             c_ptr_last = EW'(AES_ENGINE_NUM - 1);
  localparam logic [AES_ENGINE_NUM-1:0] c_all_ones = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [EW-1:0]             r_in_ptr;
  logic [EW-1:0]             r_out_ptr;
  logic [PW-1:0]             r_pend;
  logic [AES_ENGINE_NUM-1:0] r_kexp_vec;

  logic                      w_run;
  logic                      w_active;
  logic                      w_in_hs;
  logic                      w_out_hs;
  logic [AES_ENGINE_NUM-1:0] w_kexp_all;
  logic [AES_ENGINE_NUM-1:0] w_in_set;
  logic [AES_ENGINE_NUM-1:0] w_out_clr;

  assign w_run      = (r_state == ST_RUN);
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_kexp_all = r_kexp_vec | key_exp_done;

  assign eng_in_data = s_tdata;
  assign s_tready    = w_run & eng_in_ready[r_in_ptr] & ~status[r_in_ptr];
  assign m_tvalid    = w_active & status[r_out_ptr] & eng_out_valid[r_out_ptr];
  assign m_tlast     = (r_state == ST_DRAIN) && (r_pend == PW'(1));
  assign w_in_hs     = s_tvalid & s_tready;
  assign w_out_hs    = m_tvalid & m_tready;

  // Results from an engine not holding one of our blocks never reach m_tvalid.
  always_comb begin
    eng_in_valid  = '0;
    eng_out_ready = '0;
    eng_in_valid[r_in_ptr]   = w_run & s_tvalid & ~status[r_in_ptr];
    eng_out_ready[r_out_ptr] = w_active & status[r_out_ptr] & m_tready;
  end

  always_comb begin
    m_tdata = '0;
    for (int i = 0; i < AES_ENGINE_NUM; i++) begin
      if (r_out_ptr == EW'(i)) begin
        m_tdata = eng_out_data[128*i +: 128];
      end
    end
  end

  assign w_in_set  = eng_in_valid & {AES_ENGINE_NUM{s_tready}};
  assign w_out_clr = eng_out_ready & {AES_ENGINE_NUM{m_tvalid}};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state       <= ST_IDLE;
      r_in_ptr      <= '0;
      r_out_ptr     <= '0;
      r_pend        <= '0;
      r_kexp_vec    <= '0;
      status        <= '0;
      ap_done       <= 1'b0;
      key_exp_start <= 1'b0;
      eng_mode      <= 1'b0;
      eng_key_len   <= 2'b00;
    end else begin
      key_exp_start <= 1'b0;
      ap_done       <= 1'b0;
      status        <= (status | w_in_set) & ~w_out_clr;

      if (w_in_hs) begin
        r_in_ptr <= (r_in_ptr == c_ptr_last) ? '0 : r_in_ptr + EW'(1);
      end
      if (w_out_hs) begin
        r_out_ptr <= (r_out_ptr == c_ptr_last) ? '0 : r_out_ptr + EW'(1);
      end
      if (w_in_hs && !w_out_hs) begin
        r_pend <= r_pend + PW'(1);
      end else if (!w_in_hs && w_out_hs) begin
        r_pend <= r_pend - PW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            eng_mode      <= mode;
            eng_key_len   <= key_len;
            key_exp_start <= 1'b1;
            r_kexp_vec    <= '0;
            r_state       <= ST_KEYEXP;
          end
        end
        ST_KEYEXP: begin
          if (w_kexp_all == c_all_ones) begin
            r_kexp_vec <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_kexp_vec <= w_kexp_all;
          end
        end
        ST_RUN: begin
          if (w_in_hs && s_tlast) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs && m_tlast) begin
            ap_done <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // ap_start deliberately ignored here: the slave drops it on ap_done.
          r_in_ptr  <= '0;
          r_out_ptr <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_krnl_aes_engine_sched.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for krnl_aes_engine_sched: latency-modelled engines, job table and a
// result scoreboard, plus hand sequences for key-expansion timing and mid-DRAIN reset.
module tb_krnl_aes_engine_sched;

  localparam int N = 4;
  localparam logic [127:0] MASK = 128'h3c5a_96f0_0f69_a5c3_1234_5678_9abc_def0;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             ap_start = 1'b0;
  logic             ap_done;
  logic             mode = 1'b0;
  logic [1:0]       key_len = 2'b00;
  logic             eng_mode;
  logic [1:0]       eng_key_len;
  logic             key_exp_start;
  logic [N-1:0]     key_exp_done;
  logic [127:0]     s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [127:0]     eng_in_data;
  logic [N-1:0]     eng_in_valid;
  logic [N-1:0]     eng_in_ready;
  logic [128*N-1:0] eng_out_data;
  logic [N-1:0]     eng_out_valid;
  logic [N-1:0]     eng_out_ready;
  logic [127:0]     m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic [N-1:0]     status;

  krnl_aes_engine_sched #(.AES_ENGINE_NUM(N)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ap_start(ap_start), .ap_done(ap_done),
    .mode(mode), .key_len(key_len), .eng_mode(eng_mode), .eng_key_len(eng_key_len),
    .key_exp_start(key_exp_start), .key_exp_done(key_exp_done),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
    .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .status(status)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int                 nblk;
    logic               mode;
    logic [1:0]         klen;
    int                 stall_at;
    int                 stall_len;
    logic [N-1:0][3:0]  lat;
    logic [N-1:0][7:0]  kd;
    int                 exp_run;
  } job_t;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int done_cnt = 0;
  int kst_cnt  = 0;
  int job_out0 = 0;
  logic [128:0] sb[$];

  logic [N-1:0][3:0] lat;
  logic [N-1:0][7:0] kd;
  logic [N-1:0]      spur = '0;
  logic [7:0]        kcnt;
  logic [7:0]        kcur;
  logic [N-1:0]      e_busy;
  logic [3:0]        e_cnt  [N];
  logic [127:0]      e_data [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Engine model: fixed per-engine latency, result held until taken.
  always @(posedge ACLK) begin
    for (int i = 0; i < N; i++) begin
      if (!ARESETn) begin
        e_busy[i] <= 1'b0;
        e_cnt[i]  <= '0;
        e_data[i] <= '0;
      end else if (e_busy[i] && e_cnt[i] == 0 && eng_out_ready[i]) begin
        e_busy[i] <= 1'b0;
      end else if (!e_busy[i] && eng_in_valid[i]) begin
        e_busy[i] <= 1'b1;
        e_cnt[i]  <= lat[i];
        e_data[i] <= eng_in_data ^ MASK;
      end else if (e_busy[i] && e_cnt[i] != 0) begin
        e_cnt[i] <= e_cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    eng_in_ready  = '0;
    eng_out_valid = '0;
    eng_out_data  = '0;
    kcur          = key_exp_start ? 8'd1 : kcnt;
    key_exp_done  = '0;
    for (int i = 0; i < N; i++) begin
      eng_in_ready[i]            = ~e_busy[i];
      eng_out_valid[i]           = (e_busy[i] && e_cnt[i] == 0) | spur[i];
      eng_out_data[128*i +: 128] = e_data[i];
      key_exp_done[i]            = (kcur != 8'd0) && (kcur == kd[i]);
    end
  end

  // kcur numbers the cycles of key expansion; cycle 1 shows key_exp_start.
  always @(posedge ACLK) begin
    if (!ARESETn)                          kcnt <= '0;
    else if (key_exp_start)                kcnt <= 8'd2;
    else if (kcnt != 0 && kcnt < 8'd60)    kcnt <= kcnt + 8'd1;
    else                                   kcnt <= '0;
  end

  always @(negedge ACLK) begin
    logic [128:0] e;
    if (ARESETn && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", m_tdata);
      end else begin
        e = sb.pop_front();
        check("m_tdata", m_tdata, e[127:0]);
        check("m_tlast", {127'd0, m_tlast}, {127'd0, e[128]});
      end
      out_cnt++;
    end
    if (ARESETn && ap_done)       done_cnt++;
    if (ARESETn && key_exp_start) kst_cnt++;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_job(input logic md, input logic [1:0] kl, input int exp_run);
    int fr;
    fr = 0;
    mode     = md;
    key_len  = kl;
    ap_start = 1'b1;
    for (int c = 1; c <= 40 && fr == 0; c++) begin
      tick();
      if (c == 1) check("key_exp_start", {127'd0, key_exp_start}, 128'd1);
      if (s_tready) fr = c;
    end
    check("run_entry_cycle", 128'(fr), 128'(exp_run));
    check("eng_mode", {127'd0, eng_mode}, {127'd0, md});
    check("eng_key_len", {126'd0, eng_key_len}, {126'd0, kl});
    spur = '1;
    #1;
    check("spurious_valid", {127'd0, m_tvalid}, 128'd0);
    spur = '0;
  endtask

  task automatic send_blocks(input int n, input int tag);
    bit ok;
    for (int b = 0; b < n; b++) begin
      s_tdata  = {tag[7:0], b[7:0], $urandom, $urandom, $urandom, 16'h0};
      s_tlast  = (b == n - 1);
      s_tvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
        @(negedge ACLK);
        if (s_tready) ok = 1'b1;
        else @(posedge ACLK);
      end
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL s_tready_timeout: got 0 expected 1 (block %0d)", b);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge ACLK);
      sb.push_back({s_tlast, s_tdata ^ MASK});
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic stall_ctl(input int at, input int len);
    if (len > 0) begin
      for (int t = 0; t < 400 && out_cnt < job_out0 + at; t++) tick();
      m_tready = 1'b0;
      repeat (len) tick();
      check("stall_status_full", 128'(status), 128'(4'b1111));
      check("stall_s_tready", {127'd0, s_tready}, 128'd0);
      m_tready = 1'b1;
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 600 && !ap_done; t++) tick();
    check("ap_done_pulse", {127'd0, ap_done}, 128'd1);
    ap_start = 1'b0;
    tick();
    check("ap_done_single", {127'd0, ap_done}, 128'd0);
  endtask

  task automatic run_job(input job_t j, input int idx);
    int d0;
    int k0;
    lat      = j.lat;
    kd       = j.kd;
    m_tready = 1'b1;
    job_out0 = out_cnt;
    d0       = done_cnt;
    k0       = kst_cnt;
    start_job(j.mode, j.klen, j.exp_run);
    fork
      send_blocks(j.nblk, idx);
      stall_ctl(j.stall_at, j.stall_len);
    join
    wait_done();
    check("out_count", 128'(out_cnt - job_out0), 128'(j.nblk));
    check("done_count", 128'(done_cnt - d0), 128'd1);
    check("kexp_start_count", 128'(kst_cnt - k0), 128'd1);
    check("status_idle", 128'(status), 128'd0);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);
  endtask

  job_t jobs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{nblk: 8,  mode: 1'b1, klen: 2'd2, stall_at: 0, stall_len: 0,
                lat: {4'd5, 4'd2, 4'd7, 4'd4}, kd: {8'd9, 8'd5, 8'd5, 8'd3}, exp_run: 10};
    jobs[1] = '{nblk: 12, mode: 1'b0, klen: 2'd0, stall_at: 2, stall_len: 20,
                lat: {4'd5, 4'd2, 4'd7, 4'd4}, kd: {8'd1, 8'd1, 8'd1, 8'd1}, exp_run: 2};
    jobs[2] = '{nblk: 1,  mode: 1'b1, klen: 2'd1, stall_at: 0, stall_len: 0,
                lat: {4'd3, 4'd3, 4'd3, 4'd3}, kd: {8'd1, 8'd1, 8'd4, 8'd2}, exp_run: 5};
    jobs[3] = '{nblk: 16, mode: 1'b0, klen: 2'd3, stall_at: 0, stall_len: 0,
                lat: {4'd1, 4'd1, 4'd1, 4'd1}, kd: {8'd1, 8'd1, 8'd1, 8'd1}, exp_run: 2};
    lat = jobs[0].lat;
    kd  = jobs[0].kd;

    ARESETn = 1'b0;
    repeat (3) tick();
    ARESETn = 1'b1;
    check("rst_ap_done", {127'd0, ap_done}, 128'd0);
    check("rst_s_tready", {127'd0, s_tready}, 128'd0);
    check("rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
    check("rst_status", 128'(status), 128'd0);
    check("rst_eng_mode", {125'd0, eng_mode, eng_key_len}, 128'd0);
    tick();

    for (int k = 0; k < 4; k++) begin
      run_job(jobs[k], k);
      tick();
    end

    // Reset while draining three outstanding results.
    lat      = {4'd1, 4'd1, 4'd1, 4'd1};
    kd       = {8'd1, 8'd1, 8'd1, 8'd1};
    m_tready = 1'b0;
    start_job(1'b1, 2'd2, 2);
    send_blocks(3, 9);
    repeat (3) tick();
    check("drain_s_tready", {127'd0, s_tready}, 128'd0);
    check("drain_m_tvalid", {127'd0, m_tvalid}, 128'd1);
    check("drain_m_tlast", {127'd0, m_tlast}, 128'd0);
    check("drain_status", 128'(status), 128'(4'b0111));
    ARESETn  = 1'b0;
    ap_start = 1'b0;
    tick();
    check("mid_rst_status", 128'(status), 128'd0);
    check("mid_rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
    check("mid_rst_ap_done", {127'd0, ap_done}, 128'd0);
    check("mid_rst_s_tready", {127'd0, s_tready}, 128'd0);
    sb.delete();
    ARESETn  = 1'b1;
    m_tready = 1'b1;
    tick();
    run_job(jobs[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/krnl_aes_engine_sched.md
Name: krnl_aes_engine_sched

Overview:
Sequences one kernel run across AES_ENGINE_NUM AES engines. It takes ap_start, mode and key_len from the AXI control slave and triggers key expansion in every engine. It then distributes 128-bit input blocks from an AXI-Stream round-robin to the engines and collects their results in the same order. It reports per-engine busy status and pulses ap_done when the last result has left.

Parameters:
AES_ENGINE_NUM, 4, number of engines; legal 2..8
EW, $clog2(AES_ENGINE_NUM), engine index width (derived localparam)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
ap_start  in  1  level from control slave; held until ap_done
ap_done  out  1  one-cycle done pulse to control slave
mode  in  1  0=decrypt, 1=encrypt
key_len  in  2  key length code, passed through
eng_mode  out  1  latched mode to all engines
eng_key_len  out  2  latched key_len to all engines
key_exp_start  out  1  one-cycle pulse to all engines
key_exp_done  in  AES_ENGINE_NUM  per-engine expansion-complete pulse
s_tdata  in  128  input block
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  last block of job
eng_in_data  out  128  shared input bus (= s_tdata)
eng_in_valid  out  AES_ENGINE_NUM  one-hot input valid
eng_in_ready  in  AES_ENGINE_NUM  engine can accept a block
eng_out_data  in  128*AES_ENGINE_NUM  engine i result at [128*i+:128]
eng_out_valid  in  AES_ENGINE_NUM  result valid
eng_out_ready  out  AES_ENGINE_NUM  one-hot result ready
m_tdata  out  128  output block
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tlast  out  1  last output block
status  out  AES_ENGINE_NUM  bit i = engine i holds an in-flight block

Behaviour:
- Reset: ARESETn, synchronous, active-low; clock ACLK. State IDLE. ap_done, key_exp_start, s_tready, eng_in_valid, eng_out_ready, m_tvalid, m_tlast, status, eng_mode, eng_key_len, pointers and counters all 0.
- States: IDLE, KEYEXP, RUN, DRAIN, DONE.
- IDLE: when ap_start=1, latch mode and key_len into eng_mode and eng_key_len. Assert key_exp_start for exactly that transition cycle (registered, visible the next cycle). Go to KEYEXP.
- KEYEXP: a sticky vector ORs in key_exp_done bits. When the vector is all-ones (including bits arriving that cycle), clear it and go to RUN. No timeout.
- Input pointer in_ptr (EW bits, starts at 0):
  - s_tready = (state==RUN) & eng_in_ready[in_ptr] & ~status[in_ptr].
  - eng_in_valid[in_ptr] = (state==RUN) & s_tvalid & ~status[in_ptr]; all other bits 0.
  - On handshake: set status[in_ptr] and advance in_ptr, wrapping AES_ENGINE_NUM-1 -> 0.
  - If s_tlast is set on the handshake, go to DRAIN.
- Output pointer out_ptr (EW bits, starts at 0):
  - m_tvalid = (state in RUN/DRAIN) & status[out_ptr] & eng_out_valid[out_ptr].
  - m_tdata is engine out_ptr's slice. eng_out_ready[out_ptr] = m_tready under the same qualification; all other bits 0.
  - On handshake: clear status[out_ptr] and advance out_ptr with wrap.
  - Result order always equals input order.
- Outstanding counter pend ($clog2(AES_ENGINE_NUM+1) bits): +1 on input handshake, -1 on output handshake, unchanged when both occur. Never exceeds AES_ENGINE_NUM.
- m_tlast = (state==DRAIN) & (pend==1). An output handshake with m_tlast set goes to DONE.
- DONE: ap_done=1 for one cycle; in_ptr and out_ptr reset to 0; go to IDLE. ap_start is not sampled in DONE, so the slave clearing ap_start on ap_done does not cause a false restart.
- Engine out_valid asserted while status[i]=0 is ignored (not forwarded).
- ap_start changes outside IDLE are ignored; mode and key_len are stable for the whole job.
- Reset mid-operation: immediate return to the reset state. In-flight engine data is abandoned; engines are reset by the same ARESETn.
- Output paths are combinational from engine signals; no added latency. Input-to-engine has zero-cycle latency.

Test Plan:
- 4 engines, ap_start=1, key_exp_done bits arriving at cycles 3,5,5,9 -> single key_exp_start pulse; RUN is entered the cycle after bit 3 arrives (cycle 10); s_tready=0 before that.
- 8 blocks 0..7 with tlast on 7, engines of latencies 4/7/2/5 cycles -> m_tdata order 0..7; m_tlast only on block 7; ap_done one pulse after it; status returns to 0.
- m_tready held low 20 cycles mid-job -> status reaches 4'b1111, s_tready=0, pend=4, no data lost or reordered after release.
- Single-block job (tlast on first beat) -> enters DRAIN immediately; m_tlast on that one output; ap_done pulse.
- Simultaneous input and output handshakes in RUN for 10 cycles -> pend constant; pointers wrap 3->0 correctly.
- ARESETn low in DRAIN with pend=3 -> next cycle: state IDLE, status=0, m_tvalid=0, ap_done=0; a new job runs correctly.
